pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC and stall controller for the 5-stage MIPS core; drives Program_Counter new_pc/stall.
//  Chooses sequential/branch/jump/exception target; stalls PC on load-use and data-memory wait.
//  Produces IF/ID flush and ID/EX bubble; 2-bit FSM guarantees forward progress.
// PARAMETERS
//  N_BITS      32             PC/data width
//  EXC_VECTOR  32'h8000_0180  exception handler address (PC_SEQ_EXC_EN only)
//  MAX_WAIT    15             MEM_WAIT cycles before mem_timeout_o pulses
//  CNT_BITS    4              wait-counter width; must hold MAX_WAIT
// PORTS
//  clk              in   1       clock, rising edge
//  reset            in   1       asynchronous, active-low reset
//  pc_value_i       in   N_BITS  current PC (Program_Counter output)
//  branch_taken_i   in   1       ID-stage branch resolved taken
//  branch_target_i  in   N_BITS  branch target
//  jump_i           in   1       ID-stage J/JAL/JR
//  jump_target_i    in   N_BITS  jump target
//  load_use_i       in   1       load-use hazard detected in ID
//  mem_wait_i       in   1       data memory not ready
//  exc_req_i        in   1       exception request, level (PC_SEQ_EXC_EN only)
//  new_pc_o         out  N_BITS  next PC to Program_Counter
//  pc_stall_o       out  1       to Program_Counter disable; 1 = hold PC
//  if_id_flush_o    out  1       clear IF/ID register
//  id_ex_bubble_o   out  1       insert NOP into ID/EX
//  state_o          out  2       FSM state (debug)
//  mem_timeout_o    out  1       one-cycle pulse, registered
//  epc_o            out  N_BITS  faulting PC, registered (PC_SEQ_EXC_EN only)
// BEHAVIOUR
//  Reset: state RUN, wait_cnt 0, mem_timeout_o 0, epc_o 0; comb outputs follow RUN decode.
//  Outputs Mealy (state + inputs, same cycle); state/cnt/epc/timeout update on posedge clk.
//  Default: new_pc_o = pc_value_i + 4 (mod 2^N_BITS; 0xFFFF_FFFC -> 0), all flags 0.
//  States: RUN=00, LOAD_STALL=01, MEM_WAIT=10, REDIRECT=11.
//  RUN priority: mem_wait > load_use > jump > branch > sequential:
//   mem_wait_i: pc_stall_o=1; ->MEM_WAIT, cnt<=0.
//   load_use_i: pc_stall_o=1, id_ex_bubble_o=1; ->LOAD_STALL.
//   jump_i: new_pc_o=jump_target_i, if_id_flush_o=1; ->REDIRECT (jump wins if branch too).
//   branch_taken_i: new_pc_o=branch_target_i, if_id_flush_o=1; ->REDIRECT.
//  LOAD_STALL: as RUN but load_use_i ignored; else ->RUN. Max one stall per hazard.
//  REDIRECT: as RUN but jump_i/branch_taken_i ignored (flushed slot); else ->RUN.
//  MEM_WAIT: pc_stall_o=1; load_use/branch/jump ignored; cnt saturates at 2^CNT_BITS-1.
//   cnt==MAX_WAIT-1 with mem_wait_i=1: mem_timeout_o pulses next cycle; keeps waiting.
//   mem_wait_i=0: pc_stall_o=0, sequential PC; ->RUN, cnt<=0.
//  Reset mid-stall: immediate return to RUN; no pending stall/redirect retained.
// CONFIGURATION
//  PC_SEQ_EXC_EN defined: exc_req_i, epc_o exist; exc_req_i beats all in RUN/LOAD_STALL/REDIRECT:
//   new_pc_o=EXC_VECTOR, if_id_flush_o=1, id_ex_bubble_o=1, epc_o<=pc_value_i; ->REDIRECT.
//   In MEM_WAIT exc_req_i held off; taken on first non-wait cycle (must stay asserted).
//  Undefined: ports absent; EXC_VECTOR unused; all other behaviour identical.
// STRUCTURE
//  pc_seq_pkg: state localparams (S_RUN..S_REDIRECT), PC_INCR=4, default EXC_VECTOR.
//  Sub-module pc_seq_wait_counter: saturating CNT_BITS counter, clear/enable, terminal flag.
//  Top: state register, next-state/output decode, epc register, +4 adder.
// TESTING
//  pc=0x0040_0000, no requests -> new_pc_o=0x0040_0004, stall=0, state RUN.
//  load_use_i=1 two cycles -> cycle1 stall=1,bubble=1; cycle2 (LOAD_STALL) stall=0.
//  jump_i=1, branch_taken_i=1, jt=0x0040_0100 -> new_pc_o=0x0040_0100, flush=1; ignored next cycle.
//  mem_wait_i=1 20 cycles -> stall=1 all cycles; mem_timeout_o pulse once after 15th; release->RUN.
//  pc=0xFFFF_FFFC sequential -> new_pc_o=0; reset low mid-MEM_WAIT -> state_o=00 immediately.
//  EXC_EN: exc_req_i at pc=0x0040_0020 -> new_pc_o=0x8000_0180, flush+bubble, epc_o=0x0040_0020.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared state encodings and constants for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  localparam logic [1:0] S_RUN        = 2'b00;
  localparam logic [1:0] S_LOAD_STALL = 2'b01;
  localparam logic [1:0] S_MEM_WAIT   = 2'b10;
  localparam logic [1:0] S_REDIRECT   = 2'b11;

  localparam int unsigned PC_INCR            = 4;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

endpackage

`default_nettype wire

// File: rtl/pc_seq_wait_counter.sv
// ============================================================================
// Module      : pc_seq_wait_counter
// Description : Saturating wait counter with synchronous clear/enable and a
//               terminal flag raised when the count equals TERMINAL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq_wait_counter #(
  parameter int CNT_BITS = 4,
  parameter int TERMINAL = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  output logic [CNT_BITS-1:0] cnt,
  output logic                terminal
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_BITS{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign terminal = (cnt == CNT_BITS'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC select and stall/flush/bubble control for the 5-stage
//               core. Optional exception support under `PC_SEQ_EXC_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int N_BITS   = 32,
`ifdef PC_SEQ_EXC_EN
  parameter logic [N_BITS-1:0] EXC_VECTOR = N_BITS'(EXC_VECTOR_DEFAULT),
`endif
  parameter int MAX_WAIT = 15,
  parameter int CNT_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] pc_value_i,
  input  logic              branch_taken_i,
  input  logic [N_BITS-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [N_BITS-1:0] jump_target_i,
  input  logic              load_use_i,
  input  logic              mem_wait_i,
`ifdef PC_SEQ_EXC_EN
  input  logic              exc_req_i,
  output logic [N_BITS-1:0] epc_o,
`endif
  output logic [N_BITS-1:0] new_pc_o,
  output logic              pc_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic [1:0]        state_o,
  output logic              mem_timeout_o
);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [N_BITS-1:0]   pc_seq;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_term;
  logic                timeout_nxt;
  logic [CNT_BITS-1:0] wait_cnt;
`ifdef PC_SEQ_EXC_EN
  logic                take_exc;
`endif

  assign pc_seq  = pc_value_i + N_BITS'(PC_INCR);
  assign state_o = state;

  pc_seq_wait_counter #(
    .CNT_BITS (CNT_BITS),
    .TERMINAL (MAX_WAIT - 1)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt      (wait_cnt),
    .terminal (cnt_term)
  );

  always_comb begin
    new_pc_o       = pc_seq;
    pc_stall_o     = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    state_nxt      = S_RUN;
    cnt_clr        = 1'b1;
    cnt_en         = 1'b0;
    timeout_nxt    = 1'b0;
`ifdef PC_SEQ_EXC_EN
    take_exc       = 1'b0;
`endif
    if (state == S_MEM_WAIT) begin
      // A pending exception waits until memory releases the pipeline.
      if (mem_wait_i) begin
        pc_stall_o  = 1'b1;
        state_nxt   = S_MEM_WAIT;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b1;
        timeout_nxt = cnt_term;
      end
`ifdef PC_SEQ_EXC_EN
      else if (exc_req_i) begin
        take_exc = 1'b1;
      end
`endif
    end else begin
`ifdef PC_SEQ_EXC_EN
      if (exc_req_i) begin
        take_exc = 1'b1;
      end else
`endif
      if (mem_wait_i) begin
        pc_stall_o = 1'b1;
        state_nxt  = S_MEM_WAIT;
      end else if (load_use_i && (state != S_LOAD_STALL)) begin
        pc_stall_o     = 1'b1;
        id_ex_bubble_o = 1'b1;
        state_nxt      = S_LOAD_STALL;
      end else if (jump_i && (state != S_REDIRECT)) begin
        new_pc_o      = jump_target_i;
        if_id_flush_o = 1'b1;
        state_nxt     = S_REDIRECT;
      end else if (branch_taken_i && (state != S_REDIRECT)) begin
        new_pc_o      = branch_target_i;
        if_id_flush_o = 1'b1;
        state_nxt     = S_REDIRECT;
      end
    end
`ifdef PC_SEQ_EXC_EN
    if (take_exc) begin
      new_pc_o       = EXC_VECTOR;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      state_nxt      = S_REDIRECT;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_RUN;
      mem_timeout_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      mem_timeout_o <= timeout_nxt;
    end
  end

`ifdef PC_SEQ_EXC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_o <= '0;
    end else if (take_exc) begin
      epc_o <= pc_value_i;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Randomised scoreboard bench for pc_sequencer against a
//               rule-level reference model. Honours `PC_SEQ_EXC_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam int          MAX_WAIT = 15;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0180;
`ifdef PC_SEQ_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic        bubble;
    logic [1:0]  st;
    logic        tmo;
    logic [31:0] epc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_value = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        load_use = 1'b0;
  logic        mem_wait = 1'b0;
  logic        exc_req = 1'b0;
  logic [31:0] new_pc;
  logic        pc_stall, if_id_flush, id_ex_bubble, mem_timeout;
  logic [1:0]  state;
  logic [31:0] epc;

  pc_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .pc_value_i      (pc_value),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .load_use_i      (load_use),
    .mem_wait_i      (mem_wait),
`ifdef PC_SEQ_EXC_EN
    .exc_req_i       (exc_req),
    .epc_o           (epc),
`endif
    .new_pc_o        (new_pc),
    .pc_stall_o      (pc_stall),
    .if_id_flush_o   (if_id_flush),
    .id_ex_bubble_o  (id_ex_bubble),
    .state_o         (state),
    .mem_timeout_o   (mem_timeout)
  );

`ifndef PC_SEQ_EXC_EN
  assign epc = '0;
`endif

  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pushed = 0;

  // Reference model: pipeline "mode" named by the debug state code, plus the
  // number of consecutive stalled memory-wait cycles already spent.
  int          mode = 0;
  int          waited = 0;
  bit          tmo_pend = 1'b0;
  logic [31:0] epc_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      chk("new_pc", new_pc, e.npc);
      chk("pc_stall", 32'(pc_stall), 32'(e.stall));
      chk("if_id_flush", 32'(if_id_flush), 32'(e.flush));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bubble));
      chk("state", 32'(state), 32'(e.st));
      chk("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
      chk("epc", epc, e.epc);
    end
  end

  task automatic step(input bit rst_lvl, input logic [31:0] pc, input bit mw, input bit lu,
                      input bit jp, input bit br, input logic [31:0] jt, input logic [31:0] bt,
                      input bit ex);
    exp_t e;
    int   next_mode;
    bit   next_tmo;
    bit   exc_take;
    @(posedge clk);
    #1;
    reset = rst_lvl; pc_value = pc; mem_wait = mw; load_use = lu;
    jump = jp; branch_taken = br; jump_target = jt; branch_target = bt;
    exc_req = ex & EXC_ON;
    if (!rst_lvl) begin
      mode = 0; waited = 0; tmo_pend = 1'b0; epc_m = '0;
    end
    e.npc = pc + 32'd4; e.stall = 0; e.flush = 0; e.bubble = 0;
    e.st = mode[1:0]; e.tmo = tmo_pend; e.epc = epc_m;
    next_mode = 0; next_tmo = 0; exc_take = 0;
    if (mode == 2) begin
      if (mw) begin
        e.stall = 1; next_mode = 2;
        waited++;
        next_tmo = (waited == MAX_WAIT);
      end else begin
        exc_take = exc_req;
        waited = 0;
      end
    end else begin
      waited = 0;
      if (exc_req) exc_take = 1;
      else if (mw) begin e.stall = 1; next_mode = 2; end
      else if (lu && mode != 1) begin e.stall = 1; e.bubble = 1; next_mode = 1; end
      else if ((jp || br) && mode != 3) begin
        e.npc = jp ? jt : bt; e.flush = 1; next_mode = 3;
      end
    end
    if (exc_take) begin
      e.npc = EXC_VEC; e.flush = 1; e.bubble = 1; next_mode = 3;
    end
    sb.push_back(e);
    pushed++;
    if (rst_lvl) begin
      mode = next_mode; tmo_pend = next_tmo;
      if (exc_take) epc_m = pc;
    end
  endtask

  initial begin
    logic [31:0] pc;
    // Reset held for two cycles, then idle sequential fetch.
    step(0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0);
    // Load-use held two cycles: only one stall.
    step(1, 32'h0040_0004, 0, 1, 0, 0, 0, 0, 0);
    step(1, 32'h0040_0004, 0, 1, 0, 0, 0, 0, 0);
    // Jump and branch together; both ignored in the flushed slot.
    step(1, 32'h0040_0008, 0, 0, 1, 1, 32'h0040_0100, 32'h0040_0200, 0);
    step(1, 32'h0040_0100, 0, 0, 1, 1, 32'h0040_0300, 32'h0040_0400, 0);
    step(1, 32'h0040_0104, 0, 0, 0, 1, 0, 32'h0040_0500, 0);
    // Long memory wait: single timeout pulse, then release.
    for (int i = 0; i < 20; i++) step(1, 32'h0040_0500, 1, 1, 1, 1, 32'h1, 32'h2, 0);
    step(1, 32'h0040_0500, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h0040_0504, 0, 0, 0, 0, 0, 0, 0);
    // PC wrap-around.
    step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    // Exception at a known PC, then exception pending across a memory wait.
    step(1, 32'h0040_0020, 0, 1, 1, 0, 32'h0040_0600, 0, 1);
    step(1, 32'h8000_0180, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h8000_0184, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h8000_0184, 1, 0, 0, 0, 0, 0, 1);
    step(1, 32'h8000_0184, 0, 0, 0, 0, 0, 0, 1);
    // Reset asserted mid memory wait.
    for (int i = 0; i < 5; i++) step(1, 32'h0040_0700, 1, 0, 0, 0, 0, 0, 0);
    step(0, 32'h0040_0700, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h0040_0700, 0, 0, 0, 0, 0, 0, 0);
    // Randomised traffic, with occasional long waits to reach the timeout.
    for (int i = 0; i < 600; i++) begin
      int run;
      pc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 39) == 0) begin
        run = $urandom_range(12, 19);
        for (int k = 0; k < run; k++) step(1, pc, 1, $urandom_range(0, 1) == 1, 0, 0, 0, 0, 0);
      end else begin
        step(($urandom_range(0, 99) != 0), pc,
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
             ($urandom_range(0, 9) == 0));
      end
    end
    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0 || vectors != pushed) begin
      miscompares++;
      $display("FAIL scoreboard_drain: checked %0d expected %0d", vectors, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
